// File: rtl/stack.sv
// Shift-register return-address stack for the PIC16C5x core. CALL pushes and RETLW pops.
// Overflow drops the oldest entry and underflow re-reads the deepest one, with sticky debug flags.
module stack #(
  parameter int PC_W  = 9,
  parameter int DEPTH = 2,
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [PC_W-1:0]  pcIn,
  input  logic             clrFlags,
  output logic [PC_W-1:0]  stackOut,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty,
  output logic             overflow,
  output logic             underflow
);

  logic [PC_W-1:0]  level_q [DEPTH];
  logic [PC_W-1:0]  level_d [DEPTH];
  logic [CNT_W-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             full_w, empty_w;

  assign full_w  = (count_q == CNT_W'(DEPTH));
  assign empty_w = (count_q == '0);

  always_comb begin
    level_d = level_q;
    count_d = count_q;
    ovf_d   = ovf_q & ~clrFlags;
    unf_d   = unf_q & ~clrFlags;
    unique case ({push, pop})
      2'b10: begin
        level_d[0] = pcIn;
        for (int i = 1; i < DEPTH; i++) level_d[i] = level_q[i-1];
        if (full_w) ovf_d = 1'b1;
        else        count_d = count_q + CNT_W'(1);
      end
      2'b01: begin
        // The deepest level keeps its value, so underflowing pops re-read it.
        for (int i = 0; i < DEPTH - 1; i++) level_d[i] = level_q[i+1];
        if (empty_w) unf_d = 1'b1;
        else         count_d = count_q - CNT_W'(1);
      end
      2'b11: begin
        level_d[0] = pcIn;
        if (empty_w) begin
          count_d = CNT_W'(1);
          unf_d   = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) level_q[i] <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) level_q[i] <= level_d[i];
      count_q <= count_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  assign stackOut  = level_q[0];
  assign count     = count_q;
  assign full      = full_w;
  assign empty     = empty_w;
  assign overflow  = ovf_q;
  assign underflow = unf_q;

endmodule

// File: tb/tb_stack.sv
// Directed bench for the return-address stack: a reference model queues the expected
// post-edge state for each step, and the queue is compared after the clock edge.
module tb_stack;

  logic       clk = 1'b0;
  logic       rst_n, push, pop, clrFlags;
  logic [8:0] pcIn;
  logic [8:0] stackOut;
  logic [1:0] count;
  logic       full, empty, overflow, underflow;

  stack #(.PC_W(9), .DEPTH(2), .CNT_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .push(push), .pop(pop), .pcIn(pcIn),
    .clrFlags(clrFlags), .stackOut(stackOut), .count(count), .full(full),
    .empty(empty), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    logic [8:0] top;
    logic [1:0] cnt;
    logic       full, empty, ovf, unf;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [8:0] m_lvl [2];
  int         m_cnt;
  logic       m_ovf, m_unf;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic model(input logic r, input logic p, input logic po,
                       input logic [8:0] pc, input logic c);
    logic [8:0] l0, l1;
    bit was_full, was_empty;
    l0 = m_lvl[0];
    l1 = m_lvl[1];
    was_full  = (m_cnt == 2);
    was_empty = (m_cnt == 0);
    if (!r) begin
      m_lvl[0] = '0; m_lvl[1] = '0; m_cnt = 0; m_ovf = 0; m_unf = 0;
      return;
    end
    if (c) begin m_ovf = 0; m_unf = 0; end
    if (p && !po) begin
      m_lvl[0] = pc; m_lvl[1] = l0;
      if (was_full) m_ovf = 1; else m_cnt++;
    end else if (!p && po) begin
      m_lvl[0] = l1;
      if (was_empty) m_unf = 1; else m_cnt--;
    end else if (p && po) begin
      m_lvl[0] = pc;
      if (was_empty) begin m_cnt = 1; m_unf = 1; end
    end
  endtask

  task automatic step(input string tag, input logic r, input logic p, input logic po,
                      input logic [8:0] pc, input logic c);
    exp_t e;
    rst_n = r; push = p; pop = po; pcIn = pc; clrFlags = c;
    #1;
    // Pop reads the pre-pop top in the same cycle.
    if (po && r) chk({tag, "_popread"}, 16'(stackOut), 16'(m_lvl[0]));
    model(r, p, po, pc, c);
    e.tag = tag; e.top = m_lvl[0]; e.cnt = 2'(m_cnt);
    e.full = (m_cnt == 2); e.empty = (m_cnt == 0); e.ovf = m_ovf; e.unf = m_unf;
    q.push_back(e);
    @(posedge clk);
    #1;
    e = q.pop_front();
    chk({e.tag, "_top"},   16'(stackOut),  16'(e.top));
    chk({e.tag, "_count"}, 16'(count),     16'(e.cnt));
    chk({e.tag, "_full"},  16'(full),      16'(e.full));
    chk({e.tag, "_empty"}, 16'(empty),     16'(e.empty));
    chk({e.tag, "_ovf"},   16'(overflow),  16'(e.ovf));
    chk({e.tag, "_unf"},   16'(underflow), 16'(e.unf));
  endtask

  initial begin
    rst_n = 1'b0; push = 1'b0; pop = 1'b0; pcIn = '0; clrFlags = 1'b0;
    m_lvl[0] = 'x; m_lvl[1] = 'x; m_cnt = 0; m_ovf = 0; m_unf = 0;
    @(posedge clk); #1;

    step("rst1", 0, 1, 0, 9'h1AB, 0);
    step("rst2", 0, 1, 0, 9'h1AB, 0);
    chk("rst_top_const", 16'(stackOut), 16'h000);
    chk("rst_empty_const", 16'(empty), 16'h1);

    step("call1", 1, 1, 0, 9'h010, 0);
    step("call2", 1, 1, 0, 9'h020, 0);
    chk("nest_full_const", 16'(full), 16'h1);
    step("ret1", 1, 0, 1, 9'h000, 0);
    chk("nest_top_const", 16'(stackOut), 16'h010);
    step("ret2", 1, 0, 1, 9'h000, 0);

    step("ovf1", 1, 1, 0, 9'h001, 0);
    step("ovf2", 1, 1, 0, 9'h002, 0);
    step("ovf3", 1, 1, 0, 9'h003, 0);
    chk("ovf_flag_const", 16'(overflow), 16'h1);
    step("ovfpop1", 1, 0, 1, 9'h000, 0);
    chk("ovf_lvl1_const", 16'(stackOut), 16'h002);
    step("ovfpop2", 1, 0, 1, 9'h000, 0);
    step("ovfclr", 1, 0, 0, 9'h000, 1);

    // Fill both levels with 0x055 so every pop, including the underflow, reads it.
    step("unfpush1", 1, 1, 0, 9'h055, 0);
    step("unfpush2", 1, 1, 0, 9'h055, 0);
    step("unfpop1", 1, 0, 1, 9'h000, 0);
    step("unfpop2", 1, 0, 1, 9'h000, 0);
    step("unfpop3", 1, 0, 1, 9'h000, 0);
    chk("unf_flag_const", 16'(underflow), 16'h1);
    chk("unf_top_const", 16'(stackOut), 16'h055);
    step("unfclr", 1, 0, 0, 9'h000, 1);

    step("simpush1", 1, 1, 0, 9'h011, 0);
    step("simpush2", 1, 1, 0, 9'h022, 0);
    step("simrepl", 1, 1, 1, 9'h0FF, 0);
    chk("sim_top_const", 16'(stackOut), 16'h0FF);
    step("simpop1", 1, 0, 1, 9'h000, 0);
    step("simpop2", 1, 0, 1, 9'h000, 0);
    step("simempty", 1, 1, 1, 9'h044, 0);
    chk("simempty_unf_const", 16'(underflow), 16'h1);

    step("priclr", 1, 0, 0, 9'h000, 1);
    step("pripush1", 1, 1, 0, 9'h0A1, 0);
    step("pripush2", 1, 1, 0, 9'h0A2, 0);
    step("priboth", 1, 1, 0, 9'h0A3, 1);
    chk("pri_ovf_const", 16'(overflow), 16'h1);
    step("pricl2", 1, 0, 0, 9'h000, 1);
    step("idle", 1, 0, 0, 9'h1FF, 0);

    step("midpush", 1, 1, 0, 9'h123, 0);
    step("midrst", 0, 1, 0, 9'h156, 0);
    step("postrst", 1, 0, 0, 9'h000, 0);

    if (q.size() != 0) chk("queue_drained", 16'(q.size()), 16'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
